// File: rtl/fxp_seq_divider16.sv
`default_nettype none
// fxp_seq_divider16: signed Q(WIDTH-FRAC).FRAC restoring divider, one quotient bit per clock.
// Fixed WIDTH+FRAC+1 cycle latency; saturating result with overflow and divide-by-zero flags.
module fxp_seq_divider16 #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             overflow,
  output logic             div_zero
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [N-1:0]     c_max_pos = {{(FRAC+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [N-1:0]     c_max_neg = c_max_pos + 1'b1;
  localparam logic [WIDTH-1:0] c_sat_pos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_sat_neg = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [CW-1:0]    r_cnt;
  logic [N-1:0]     r_num;
  logic [WIDTH:0]   r_rem;
  logic [N-1:0]     r_q;
  logic [WIDTH:0]   r_dvs;
  logic             r_sign;
  logic             r_dz;
  logic             r_dvd_neg;

  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic             r_ovf;
  logic             r_divz;

  logic [WIDTH:0]   w_dvd_ext;
  logic [WIDTH:0]   w_dvs_ext;
  logic [WIDTH:0]   w_dvd_mag;
  logic [WIDTH:0]   w_dvs_mag;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_ge;
  logic             w_last;
  logic [WIDTH-1:0] w_q_neg;
  logic [WIDTH-1:0] w_fix_q;
  logic             w_fix_ovf;

  // Magnitudes carry one extra bit so that -2^(WIDTH-1) stays exact.
  assign w_dvd_ext = {dividend[WIDTH-1], dividend};
  assign w_dvs_ext = {divisor[WIDTH-1], divisor};
  assign w_dvd_mag = dividend[WIDTH-1] ? -w_dvd_ext : w_dvd_ext;
  assign w_dvs_mag = divisor[WIDTH-1]  ? -w_dvs_ext : w_dvs_ext;

  assign w_shift = {r_rem, r_num[N-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_trial[WIDTH+1];
  assign w_last  = (r_cnt == CW'(N - 1));
  assign w_q_neg = -r_q[WIDTH-1:0];

  always_comb begin
    w_fix_q   = r_sign ? w_q_neg : r_q[WIDTH-1:0];
    w_fix_ovf = 1'b0;
    if (r_dz) begin
      w_fix_q = r_dvd_neg ? c_sat_neg : c_sat_pos;
    end else if (!r_sign && (r_q > c_max_pos)) begin
      w_fix_q   = c_sat_pos;
      w_fix_ovf = 1'b1;
    end else if (r_sign && (r_q > c_max_neg)) begin
      w_fix_q   = c_sat_neg;
      w_fix_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_DIV;
      S_DIV:   if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_num     <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_dvs     <= '0;
      r_sign    <= 1'b0;
      r_dz      <= 1'b0;
      r_dvd_neg <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt     <= '0;
            r_num     <= N'(w_dvd_mag) << FRAC;
            r_rem     <= '0;
            r_q       <= '0;
            r_dvs     <= w_dvs_mag;
            r_sign    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_dz      <= (divisor == '0);
            r_dvd_neg <= dividend[WIDTH-1];
          end
        end
        S_DIV: begin
          r_rem <= w_ge ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
          r_q   <= {r_q[N-2:0], w_ge};
          r_num <= {r_num[N-2:0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_quot <= '0;
      r_ovf  <= 1'b0;
      r_divz <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      if (r_state == S_FIX) begin
        r_quot <= w_fix_q;
        r_ovf  <= w_fix_ovf;
        r_divz <= r_dz;
      end
    end
  end

  assign done     = r_done;
  assign quotient = r_quot;
  assign overflow = r_ovf;
  assign div_zero = r_divz;

endmodule
`default_nettype wire

// File: tb/tb_fxp_seq_divider16.sv
`default_nettype none
// tb_fxp_seq_divider16: directed self-checking bench for the sequential fixed-point divider.
module tb_fxp_seq_divider16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic        overflow;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;

  fxp_seq_divider16 #(.WIDTH(16), .FRAC(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .overflow (overflow),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge; returns in the done cycle, 1 unit after its edge.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic ov, output logic dz,
                         output int lat, output logic bsy_ok);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    lat    = 0;
    bsy_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) bsy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b0) bsy_ok = 1'b0;
    q  = quotient;
    ov = overflow;
    dz = div_zero;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    checks++;
    if ({busy, done, quotient, overflow, div_zero} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h ovf=%b dz=%b, required all 0",
               busy, done, quotient, overflow, div_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [15:0] q; logic ov, dz, bok; int lat;
    run_div(16'h0300, 16'h0200, q, ov, dz, lat, bok);
    checks++;
    if (q !== 16'h0180) begin failures++; $display("FAIL basic_q: got %h required 0180", q); end
    checks++;
    if ({ov, dz} !== 2'b00) begin failures++; $display("FAIL basic_flags: got ovf=%b dz=%b required 0 0", ov, dz); end
    checks++;
    if (lat !== 25) begin failures++; $display("FAIL basic_latency: got %0d required 25", lat); end
    checks++;
    if (bok !== 1'b1) begin failures++; $display("FAIL basic_busy: busy profile wrong (got %b required 1)", bok); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || quotient !== 16'h0180) begin
      failures++;
      $display("FAIL basic_pulse_hold: got done=%b q=%h required done=0 q=0180", done, quotient);
    end
  endtask

  task automatic test_sign_trunc;
    logic [15:0] ta [4] = '{16'hFF00, 16'h0100, 16'hFF00, 16'h0000};
    logic [15:0] tb [4] = '{16'h0400, 16'h0300, 16'h0300, 16'hFF00};
    logic [15:0] te [4] = '{16'hFFC0, 16'h0055, 16'hFFAB, 16'h0000};
    logic [15:0] q; logic ov, dz, bok; int lat;
    for (int i = 0; i < 4; i++) begin
      run_div(ta[i], tb[i], q, ov, dz, lat, bok);
      checks++;
      if (q !== te[i] || ov !== 1'b0 || dz !== 1'b0) begin
        failures++;
        $display("FAIL sign_%0d: %h/%h got q=%h ovf=%b dz=%b required q=%h ovf=0 dz=0",
                 i, ta[i], tb[i], q, ov, dz, te[i]);
      end
    end
  endtask

  task automatic test_saturation;
    logic [15:0] ta [4] = '{16'h7F00, 16'h8000, 16'h8000, 16'h8000};
    logic [15:0] tb [4] = '{16'h0080, 16'hFF00, 16'h0100, 16'h0080};
    logic [15:0] te [4] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
    logic        to [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] q; logic ov, dz, bok; int lat;
    for (int i = 0; i < 4; i++) begin
      run_div(ta[i], tb[i], q, ov, dz, lat, bok);
      checks++;
      if (q !== te[i] || ov !== to[i] || dz !== 1'b0) begin
        failures++;
        $display("FAIL sat_%0d: %h/%h got q=%h ovf=%b dz=%b required q=%h ovf=%b dz=0",
                 i, ta[i], tb[i], q, ov, dz, te[i], to[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [15:0] ta [2] = '{16'h0100, 16'hFE00};
    logic [15:0] te [2] = '{16'h7FFF, 16'h8000};
    logic [15:0] q; logic ov, dz, bok; int lat;
    for (int i = 0; i < 2; i++) begin
      run_div(ta[i], 16'h0000, q, ov, dz, lat, bok);
      checks++;
      if (q !== te[i] || ov !== 1'b0 || dz !== 1'b1 || lat !== 25) begin
        failures++;
        $display("FAIL divzero_%0d: got q=%h ovf=%b dz=%b lat=%0d required q=%h ovf=0 dz=1 lat=25",
                 i, q, ov, dz, lat, te[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    dividend = 16'h0300; divisor = 16'h0200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    dividend = 16'h0100; divisor = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 6;
    while (done !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    checks++;
    if (quotient !== 16'h0180 || overflow !== 1'b0 || lat !== 25) begin
      failures++;
      $display("FAIL ignore_start: got q=%h ovf=%b lat=%0d required q=0180 ovf=0 lat=25",
               quotient, overflow, lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    dividend = 16'h0100; divisor = 16'h0300; start = 1'b1;
    @(posedge clk); #1;
    dividend = 16'hFF00; divisor = 16'h0400;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    checks++;
    if (quotient !== 16'h0055 || lat !== 25) begin
      failures++;
      $display("FAIL b2b_first: got q=%h lat=%0d required q=0055 lat=25", quotient, lat);
    end
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    checks++;
    if (quotient !== 16'hFFC0 || lat !== 25) begin
      failures++;
      $display("FAIL b2b_second: got q=%h lat=%0d required q=FFC0 lat=25", quotient, lat);
    end
  endtask

  task automatic test_reset_abort;
    logic [15:0] q; logic ov, dz, bok; int lat;
    logic saw_done;
    dividend = 16'h0300; divisor = 16'h0200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, overflow, div_zero} !== 20'h0) begin
      failures++;
      $display("FAIL abort_outputs: got busy=%b done=%b q=%h ovf=%b dz=%b, required all 0",
               busy, done, quotient, overflow, div_zero);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: got done pulse=%b required 0", saw_done);
    end
    run_div(16'h0300, 16'h0200, q, ov, dz, lat, bok);
    checks++;
    if (q !== 16'h0180 || ov !== 1'b0 || dz !== 1'b0 || lat !== 25) begin
      failures++;
      $display("FAIL abort_restart: got q=%h ovf=%b dz=%b lat=%0d required q=0180 ovf=0 dz=0 lat=25",
               q, ov, dz, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_trunc();
    test_saturation();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
